vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Produces the `hcount`/`vcount` raster counters consumed by the VGA colour generator.
- Generates the VGA `hsync`/`vsync`/active-video timing.
- Delays sync and active signals to match the colour generator's registered latency.
- Gates the returned `rgb` to black outside the active area, then drives the physical VGA pins.
- Sits between the system clock domain and the VGA connector, on the same clock as the colour generator.

Parameters:
CLK_DIV, 2, system clocks per pixel (≥1); pixel enable asserted once every CLK_DIV clocks
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL=sum of H_*, must be ≤2048
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL=sum of V_*, must be ≤1024
HS_POL, 0, hsync asserted level (0=active-low)
VS_POL, 0, vsync asserted level (0=active-low)
LAT, 1, clocks of latency of the colour source from hcount/vcount to rgb_in (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
hcount  out  11  current pixel column, 0..H_TOTAL-1
vcount  out  10  current line, 0..V_TOTAL-1
pix_ce  out  1  1-clk pixel enable pulse
active  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE (undelayed)
line_start  out  1  1-clk pulse when hcount wraps to 0
frame_start  out  1  1-clk pulse when hcount and vcount both wrap to 0
rgb_in  in  6  {r[1:0],g[1:0],b[1:0]} from colour generator, LAT clocks behind counts
vga_hs  out  1  horizontal sync pin
vga_vs  out  1  vertical sync pin
vga_r  out  2  red pin
vga_g  out  2  green pin
vga_b  out  2  blue pin

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous, active-high, and has priority over all other logic.
- Reset values:
  - hcount=0, vcount=0, divider=0, pix_ce=0, active=1, line_start=0, frame_start=0.
  - vga_hs=~HS_POL, vga_vs=~VS_POL, vga_r/g/b=0.
  - Delay-line stages reset to inactive: sync deasserted, de=0.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_ce=1 (registered) in the clock where the divider equals CLK_DIV-1.
  - CLK_DIV=1 gives pix_ce=1 every clock after reset.
- Counters (advance only on clocks where pix_ce=1):
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount at V_TOTAL-1 wraps to 0.
  - Counts are held constant for CLK_DIV clocks each.
- active, line_start, frame_start:
  - Registered, valid in the same cycle as the counts they describe (decode from next-count values).
  - line_start and frame_start last exactly 1 clk, not CLK_DIV clocks.
  - Reset does not generate line_start or frame_start.
- Raw sync decode:
  - hs asserted when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC.
  - Polarity applied via HS_POL/VS_POL.
- Delay line:
  - Raw hs, vs and active pass through a LAT-deep clocked shift register (every clk, not pix_ce).
- Output stage, registered every clk:
  - vga_hs/vga_vs = delayed hs/vs.
  - {vga_r,vga_g,vga_b} = delayed active ? rgb_in : 0.
  - Net pin latency from a count change is LAT+1 clocks; rgb_in is sampled exactly LAT clocks after the count it belongs to.
- Reset mid-frame: all state returns to reset values on the next clock; raster restarts at (0,0) with no glitch pulses on line_start or frame_start.
- Width rules: counts never exceed H_TOTAL-1 / V_TOTAL-1; illegal parameter totals are out of scope (elaboration assertion recommended).

Test Plan:
1. Defaults, release rst at t0 -> hcount=0 for 2 clks, 1 for next 2; after 1600 clks hcount 799→0, vcount 0→1, line_start high for exactly 1 clk.
2. Defaults, free-run -> hsync decode low exactly for hcount 656..751 (high at 655, 752); vga_hs follows 2 clks later; vsync low for vcount 490..491 only.
3. Defaults, count frame_start pulses -> exactly one per 840000 clks (800×525×2), coincident with hcount=0 and vcount=0.
4. rgb_in=6'h3F constant -> vga pins =2'b11 only while delayed active; pins=0 from the clock after hcount 639's delayed window through line end, and during vcount 480..524.
5. rst asserted 1 clk at hcount=300, vcount=200 -> next clk hcount=0, vcount=0, vga_hs=vga_vs=1, rgb pins=0, no line_start/frame_start pulse; raster restarts cleanly.
6. CLK_DIV=1, LAT=3 -> pix_ce stuck 1, hcount wraps every 800 clks, vga_hs falls 4 clks after hcount reaches 656.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, hcount/vcount counters, sync/active decode,
// a LAT-deep delay line to align with the colour source, and the registered pin stage.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        pix_ce,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    input  logic [5:0]  rgb_in,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [1:0]  vga_r,
    output logic [1:0]  vga_g,
    output logic [1:0]  vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int          DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             pix_ce_q, pix_ce_d;
    logic             active_q, active_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             hs_raw, vs_raw;
    logic [LAT-1:0]   hs_dly_q, vs_dly_q, de_dly_q;
    logic             vga_hs_q, vga_hs_d;
    logic             vga_vs_q, vga_vs_d;
    logic [5:0]       rgb_q, rgb_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pix_ce_d      = (div_d == DIV_LAST);
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        // Decoded from the next counts so the flag lines up with the counts it describes.
        active_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);

        // Sync is carried as "asserted" through the delay line; polarity applies at the pin.
        hs_raw   = (hcount_q >= HS_START) && (hcount_q < HS_END);
        vs_raw   = (vcount_q >= VS_START) && (vcount_q < VS_END);
        vga_hs_d = hs_dly_q[LAT-1] ? HS_POL : ~HS_POL;
        vga_vs_d = vs_dly_q[LAT-1] ? VS_POL : ~VS_POL;
        rgb_d    = de_dly_q[LAT-1] ? rgb_in : 6'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            pix_ce_q      <= 1'b0;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            // NOTE: the delay line is reset too, otherwise stale sync/de would reach the pins after reset.
            hs_dly_q      <= '0;
            vs_dly_q      <= '0;
            de_dly_q      <= '0;
            vga_hs_q      <= ~HS_POL;
            vga_vs_q      <= ~VS_POL;
            rgb_q         <= '0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pix_ce_q      <= pix_ce_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hs_dly_q[0]   <= hs_raw;
            vs_dly_q[0]   <= vs_raw;
            de_dly_q[0]   <= active_q;
            for (int i = 1; i < LAT; i++) begin
                hs_dly_q[i] <= hs_dly_q[i-1];
                vs_dly_q[i] <= vs_dly_q[i-1];
                de_dly_q[i] <= de_dly_q[i-1];
            end
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hcount                  = hcount_q;
    assign vcount                  = vcount_q;
    assign pix_ce                  = pix_ce_q;
    assign active                  = active_q;
    assign line_start              = line_start_q;
    assign frame_start             = frame_start_q;
    assign vga_hs                  = vga_hs_q;
    assign vga_vs                  = vga_vs_q;
    assign {vga_r, vga_g, vga_b}   = rgb_q;

endmodule
